// File: rtl/reverb_pkg.sv
// Shared constants for the reverb delay-line scheduler.
//   NUM_TAPS  : comb taps served per frame
//   TAP_LEN   : per-tap circular buffer length (samples)
//   TAP_BASE  : per-tap base address in the shared delay RAM
//   state_t   : scheduler FSM states
package reverb_pkg;

  localparam int NUM_TAPS = 4;
  localparam int LEN_W    = 13;

  // Index [i] is tap i.
  localparam logic [NUM_TAPS-1:0][LEN_W-1:0] TAP_LEN =
    {13'd1356, 13'd1277, 13'd1188, 13'd1116};
  // Taps are packed back to back: TAP_BASE[i+1] = TAP_BASE[i] + TAP_LEN[i].
  localparam logic [NUM_TAPS-1:0][LEN_W-1:0] TAP_BASE =
    {13'd3581, 13'd2304, 13'd1116, 13'd0};

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    XCHG,
    WR_REQ,
    ADVANCE
  } state_t;

endpackage

// File: rtl/reverb_tap_addr.sv
// Combinational per-tap address generator.
//   tap_len, tap_base : constants of the selected tap
//   wptr              : current write pointer of the selected tap
//   fx_size           : latched room size
//   rd_addr           : delayed read address (circular within the tap)
//   wr_addr           : write address (base + wptr)
module reverb_tap_addr #(
  parameter int PARAM_W = 7,
  parameter int ADDR_W  = 13
) (
  input  logic [ADDR_W-1:0]  tap_len,
  input  logic [ADDR_W-1:0]  tap_base,
  input  logic [ADDR_W-1:0]  wptr,
  input  logic [PARAM_W-1:0] fx_size,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0]  wr_addr
);

  localparam int PROD_W = ADDR_W + PARAM_W + 1;

  logic [PARAM_W:0]   size_p1;
  logic [PROD_W-1:0]  prod;
  logic [ADDR_W-1:0]  scaled;
  logic [ADDR_W-1:0]  delay;
  logic [ADDR_W-1:0]  rd_off;

  always_comb begin
    // (fx_size+1)/2^PARAM_W scales the delay; full size gives exactly tap_len.
    size_p1 = {1'b0, fx_size} + (PARAM_W+1)'(1);
    prod    = PROD_W'(tap_len) * PROD_W'(size_p1);
    scaled  = ADDR_W'(prod >> PARAM_W);
    // Zero delay would read the slot about to be written; clamp to 1.
    delay   = (scaled == '0) ? ADDR_W'(1) : scaled;
    rd_off  = (wptr >= delay) ? (wptr - delay) : (wptr + tap_len - delay);
    rd_addr = tap_base + rd_off;
    wr_addr = tap_base + wptr;
  end

endmodule

// File: rtl/reverb_tap_scheduler.sv
// Reverb delay-line scheduler: per frame, one read then one write per tap
// against the shared single-port delay RAM.
//   clk, reset     : clock, synchronous active-high reset
//   sample_en      : frame strobe (fx_size latched here)
//   busy, overrun  : frame in progress; sticky strobe-while-busy flag
//   tap_rd_data    : delayed samples, taps_valid pulses when all updated
//   tap_wr_data    : feedback samples, accepted on wr_valid during exchange
//   frame_done     : one-cycle pulse at frame end (pointers advance)
//   mem_*          : RAM request/grant/read-return interface
module reverb_tap_scheduler #(
  parameter int DATA_W   = 16,
  parameter int PARAM_W  = 7,
  parameter int ADDR_W   = 13,
  parameter int NUM_TAPS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_en,
  input  logic [PARAM_W-1:0]               fx_size,
  output logic                             busy,
  output logic                             overrun,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]  tap_rd_data,
  output logic                             taps_valid,
  input  logic [NUM_TAPS-1:0][DATA_W-1:0]  tap_wr_data,
  input  logic                             wr_valid,
  output logic                             frame_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_gnt,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_rvalid
);

  import reverb_pkg::*;

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  state_t                           state, state_nx;
  logic [IDX_W-1:0]                 idx;
  logic [PARAM_W-1:0]               size_q;
  logic [NUM_TAPS-1:0][ADDR_W-1:0]  wptr;
  logic [NUM_TAPS-1:0][DATA_W-1:0]  wr_q;
  logic                             xchg_d;
  logic                             last;
  logic [ADDR_W-1:0]                rd_addr, wr_addr;

  assign last = (idx == IDX_W'(NUM_TAPS-1));

  // Single shared address generator; everything it sees is held stable
  // while a request waits for grant, so mem_addr is stable too.
  reverb_tap_addr #(
    .PARAM_W (PARAM_W),
    .ADDR_W  (ADDR_W)
  ) u_addr (
    .tap_len  (ADDR_W'(TAP_LEN[idx])),
    .tap_base (ADDR_W'(TAP_BASE[idx])),
    .wptr     (wptr[idx]),
    .fx_size  (size_q),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_en)  state_nx = RD_REQ;
      RD_REQ:  if (mem_gnt)    state_nx = RD_WAIT;
      RD_WAIT: if (mem_rvalid) state_nx = last ? XCHG : RD_REQ;
      XCHG:    if (wr_valid)   state_nx = WR_REQ;
      WR_REQ:  if (mem_gnt)    state_nx = last ? ADVANCE : WR_REQ;
      ADVANCE:                 state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Moore outputs: nothing here depends on same-cycle inputs.
  always_comb begin
    busy       = (state != IDLE);
    mem_req    = (state == RD_REQ) || (state == WR_REQ);
    mem_we     = (state == WR_REQ);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == RD_REQ) mem_addr = rd_addr;
    if (state == WR_REQ) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_q[idx];
    end
    taps_valid = (state == XCHG) && !xchg_d;
    frame_done = (state == ADVANCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      size_q      <= '0;
      wptr        <= '0;
      tap_rd_data <= '0;
      wr_q        <= '0;
      overrun     <= 1'b0;
      xchg_d      <= 1'b0;
    end else begin
      xchg_d <= (state == XCHG);
      if (sample_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_en) begin
          size_q <= fx_size;
          idx    <= '0;
        end
        RD_WAIT: if (mem_rvalid) begin
          tap_rd_data[idx] <= mem_rdata;
          if (!last) idx <= idx + IDX_W'(1);
        end
        XCHG: if (wr_valid) begin
          wr_q <= tap_wr_data;
          idx  <= '0;
        end
        WR_REQ: if (mem_gnt && !last) idx <= idx + IDX_W'(1);
        ADVANCE: begin
          for (int i = 0; i < NUM_TAPS; i++)
            wptr[i] <= (wptr[i] == ADDR_W'(TAP_LEN[i]) - ADDR_W'(1)) ?
                       '0 : wptr[i] + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
